// File: rtl/coax_trig_tx_pkg.sv
// rtl/coax_trig_tx_pkg.sv - shared constants, state encoding and width helper for the coax trigger transmitter
package trig_tx_pkg;

   localparam int NBITS           = 4;
   localparam int NPHASE          = 4;
   localparam int DEF_SYNC_PULSES = 54;
   localparam int DEF_QUIET_TICKS = 220;
   localparam int DEF_DEAD_FRAMES = 3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_QUIET = 2'd1,
      ST_SYNC  = 2'd2,
      ST_HOLD  = 2'd3
   } tx_state_t;

   // Bits needed to hold values 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/coax_trig_tx_if.sv
// rtl/coax_trig_tx_if.sv - trigger board side signal bundle of the coax trigger transmitter
interface coax_trig_tx_if;
   import trig_tx_pkg::*;

   logic                    clk_locked;
   logic [NBITS-1:0]        trig_in;
   logic                    sync_win;
   logic                    resethist;
   logic                    coax_out;
   logic                    sync_busy;
   logic                    sync_abort;
   logic [NBITS-1:0][31:0]  sent_count;

   modport master (
      output clk_locked, trig_in, sync_win, resethist,
      input  coax_out, sync_busy, sync_abort, sent_count
   );

   modport slave (
      input  clk_locked, trig_in, sync_win, resethist,
      output coax_out, sync_busy, sync_abort, sent_count
   );

endinterface

// File: rtl/coax_trig_tx_slot.sv
// rtl/coax_trig_tx_slot.sv - pending flag and dead-frame holdoff counter for one trigger bit
module coax_tx_slot
   import trig_tx_pkg::*;
#(
   parameter int DEAD_FRAMES = DEF_DEAD_FRAMES
) (
   input  logic clk_adc,
   input  logic nrst,
   input  logic clr,
   input  logic en,
   input  logic edge_in,
   input  logic slot_hit,
   input  logic frame_end,
   output logic fire
);

   localparam int            DW      = cnt_width(DEAD_FRAMES);
   localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_FRAMES);

   logic          pending;
   logic [DW-1:0] dead;

   assign fire = en & slot_hit & pending;

   // Firing wins over a coincident edge, so a retrigger in the send tick is dropped.
   always_ff @(posedge clk_adc or negedge nrst) begin
      if (!nrst) begin
         pending <= 1'b0;
         dead    <= '0;
      end else if (clr) begin
         pending <= 1'b0;
         dead    <= '0;
      end else if (fire) begin
         pending <= 1'b0;
         dead    <= DEAD_LD;
      end else begin
         if (en && edge_in && (dead == '0)) begin
            pending <= 1'b1;
         end
         if (frame_end && (dead != '0)) begin
            dead <= dead - DW'(1);
         end
      end
   end

endmodule

// File: rtl/coax_trig_tx.sv
// rtl/coax_trig_tx.sv - time-slotted serial trigger transmitter with calibration sync bursts
// Optional per-bit transmit statistics: define COAX_TX_STATS_EN.
module coax_trig_tx
   import trig_tx_pkg::*;
#(
   parameter int SYNC_PULSES = DEF_SYNC_PULSES,
   parameter int QUIET_TICKS = DEF_QUIET_TICKS,
   parameter int DEAD_FRAMES = DEF_DEAD_FRAMES
) (
   input  logic           clk_adc,
   input  logic           nrst,
   coax_trig_tx_if.slave  bus
);

   localparam int            TW         = cnt_width(QUIET_TICKS);
   localparam int            PW         = cnt_width(SYNC_PULSES);
   localparam logic [TW-1:0] TICK_LAST  = TW'(QUIET_TICKS - 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(SYNC_PULSES - 1);

   logic [1:0]        ph;
   logic [NBITS-1:0]  trig_q;
   logic [NBITS-1:0]  trig_d;
   logic [NBITS-1:0]  trig_edge;
   logic [NBITS-1:0]  fire;
   logic              sync_q;
   logic              sync_d;
   logic              win_rise;

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [TW-1:0]     tick_cnt;
   logic [TW-1:0]     tick_nxt;
   logic [PW-1:0]     pulse_cnt;
   logic [PW-1:0]     pulse_nxt;
   logic              coax_q;
   logic              coax_nxt;
   logic              abort_q;
   logic              abort_nxt;
   logic              clr_slots;
   logic              slot_en;

   // Window history resets high so a window already open at reset release
   // is not mistaken for a fresh rising edge.
   always_ff @(posedge clk_adc or negedge nrst) begin
      if (!nrst) begin
         ph     <= 2'd0;
         trig_q <= '0;
         trig_d <= '0;
         sync_q <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         ph     <= ph + 2'd1;
         trig_q <= bus.trig_in;
         trig_d <= trig_q;
         sync_q <= bus.sync_win;
         sync_d <= sync_q;
      end
   end

   assign trig_edge = trig_q & ~trig_d;
   assign win_rise  = sync_q & ~sync_d;
   assign clr_slots = !bus.clk_locked || ((state == ST_RUN) && win_rise);
   assign slot_en   = bus.clk_locked && (state == ST_RUN) && !win_rise;

   for (genvar k = 0; k < NBITS; k++) begin : g_slot
      coax_tx_slot #(
         .DEAD_FRAMES (DEAD_FRAMES)
      ) u_slot (
         .clk_adc   (clk_adc),
         .nrst      (nrst),
         .clr       (clr_slots),
         .en        (slot_en),
         .edge_in   (trig_edge[k]),
         .slot_hit  (ph == 2'(k)),
         .frame_end (ph == 2'(NPHASE - 1)),
         .fire      (fire[k])
      );
   end

   always_ff @(posedge clk_adc or negedge nrst) begin
      if (!nrst) begin
         state     <= ST_RUN;
         tick_cnt  <= '0;
         pulse_cnt <= '0;
         coax_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         tick_cnt  <= tick_nxt;
         pulse_cnt <= pulse_nxt;
         coax_q    <= coax_nxt;
         abort_q   <= abort_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tick_nxt  = tick_cnt;
      pulse_nxt = pulse_cnt;
      coax_nxt  = 1'b0;
      abort_nxt = 1'b0;
      if (!bus.clk_locked) begin
         state_nxt = ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (win_rise) begin
                  state_nxt = ST_QUIET;
                  tick_nxt  = '0;
               end else begin
                  coax_nxt = |fire;
               end
            end
            ST_QUIET: begin
               if (!sync_q) begin
                  state_nxt = ST_RUN;
                  abort_nxt = 1'b1;
               end else if (tick_cnt == TICK_LAST) begin
                  state_nxt = ST_SYNC;
                  pulse_nxt = '0;
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end
            ST_SYNC: begin
               if (!sync_q) begin
                  state_nxt = ST_RUN;
                  abort_nxt = 1'b1;
               end else if (ph == 2'd0) begin
                  coax_nxt  = 1'b1;
                  pulse_nxt = pulse_cnt + PW'(1);
                  if (pulse_cnt == PULSE_LAST) begin
                     state_nxt = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!sync_q) begin
                  state_nxt = ST_RUN;
               end
            end
            default: begin
               state_nxt = ST_RUN;
            end
         endcase
      end
   end

   assign bus.coax_out   = coax_q;
   assign bus.sync_abort = abort_q;
   assign bus.sync_busy  = (state == ST_QUIET) || (state == ST_SYNC);

`ifdef COAX_TX_STATS_EN
   logic [NBITS-1:0][31:0] sent_q;

   // A clear request outranks a transmission landing in the same tick.
   always_ff @(posedge clk_adc or negedge nrst) begin
      if (!nrst) begin
         sent_q <= '0;
      end else if (bus.resethist) begin
         sent_q <= '0;
      end else begin
         for (int k = 0; k < NBITS; k++) begin
            if (fire[k]) begin
               sent_q[k] <= sent_q[k] + 32'd1;
            end
         end
      end
   end

   assign bus.sent_count = sent_q;
`else
   logic unused_resethist;

   assign unused_resethist = bus.resethist;
   assign bus.sent_count   = '0;
`endif

endmodule

// File: doc/coax_trig_tx.md
COAX_TRIG_TX -- requirements
Module: coax_trig_tx

Interface
REQ-001 SHALL have parameter SYNC_PULSES, default 54: sync pulses sent per calibration window.
REQ-002 SHALL have parameter QUIET_TICKS, default 220: idle ticks after window opens, before sync starts.
REQ-003 SHALL have parameter DEAD_FRAMES, default 3: per-bit holdoff after a sent trigger, in 4-tick frames.
REQ-004 SHALL have port clk_adc, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port clk_locked, input, 1: PLL lock; low means transmitter forced quiet.
REQ-007 SHALL have port trig_in, input, 4: trigger bits; a rising edge requests transmission of that bit.
REQ-008 SHALL have port sync_win, input, 1: calibration window level, driven by the trigger board spare line.
REQ-009 SHALL have port resethist, input, 1: clears statistics counters.
REQ-010 SHALL have port coax_out, output, 1: registered serial trigger line.
REQ-011 SHALL have port sync_busy, output, 1: high in QUIET or SYNC.
REQ-012 SHALL have port sync_abort, output, 1: one-tick pulse when the window closes before sync completes.
REQ-013 SHALL have port sent_count, output, 4x32: per-bit count of transmitted triggers.

Function
REQ-014 SHALL run a free-running 2-bit phase counter ph, incrementing every tick; slot k carries trigger bit k.
REQ-015 SHALL register trig_in once; a rising edge of bit k sets pending[k] unless dead[k] is nonzero.
REQ-016 RUN: on an edge with ph==k and pending[k], SHALL set coax_out<=1, clear pending[k] and load dead[k]<=DEAD_FRAMES; otherwise coax_out<=0. Latency from registered edge to coax_out high: 1 to 4 ticks.
REQ-017 A new edge of bit k arriving in the same tick it is transmitted SHALL be discarded; no second pulse.
REQ-018 dead[k] SHALL decrement once per frame (on ph==3) down to 0 and saturate there.
REQ-019 The state machine SHALL have states RUN, QUIET, SYNC, HOLD; sync_win SHALL be registered once before use.
REQ-020 RUN->QUIET on the sync_win rising edge: clear all pending and dead, zero the tick counter, coax_out<=0.
REQ-021 QUIET->SYNC when the tick counter reaches QUIET_TICKS-1; coax_out SHALL stay 0 in QUIET.
REQ-022 SYNC: on each ph==0 tick, coax_out<=1 and the pulse counter increments; on all other ticks coax_out<=0. After SYNC_PULSES pulses SHALL go to HOLD.
REQ-023 HOLD: coax_out 0, trig_in ignored; HOLD->RUN when registered sync_win is low.
REQ-024 Falling sync_win in QUIET or SYNC SHALL go directly to RUN and pulse sync_abort for 1 tick; a partial pulse train is not completed.
REQ-025 clk_locked low SHALL force coax_out 0, state RUN, and clear pending and dead, taking priority over all other behaviour; ph keeps counting.
REQ-026 Tick and pulse counters SHALL be wide enough for QUIET_TICKS and SYNC_PULSES and SHALL never wrap within a window.

Reset
REQ-027 nrst low SHALL asynchronously set coax_out=0, sync_busy=0, sync_abort=0, ph=0, state RUN, pending=0, dead=0, all counters and sent_count=0.
REQ-028 Reset asserted mid-SYNC SHALL abandon the window; after release the block stays in RUN until the next sync_win rising edge.

Configuration
REQ-029 Macro COAX_TX_STATS_EN defined: sent_count[k] SHALL increment (wrapping at 2^32) on each bit-k transmission and clear on resethist; clear wins when both occur in the same tick.
REQ-030 Macro COAX_TX_STATS_EN undefined: sent_count ports SHALL remain and be tied to 0, with no counter logic.

Structure
REQ-031 Package trig_tx_pkg SHALL hold the state enum, NBITS=4, NPHASE=4 and the default parameter constants.
REQ-032 Sub-module coax_tx_slot (pending flag plus dead counter for one bit) SHALL be instantiated 4 times.

Verification
REQ-033 Bit 2 edge at ph==0 -> one coax_out pulse at the ph==2 slot, sent_count[2]=1.
REQ-034 Bit 1 edges 2 frames apart (DEAD_FRAMES=3) -> exactly one pulse; an edge 4 frames later -> second pulse.
REQ-035 sync_win rises and stays high 700 ticks -> 220 quiet ticks, then exactly 54 pulses on ph==0, then coax_out stays 0 until sync_win falls.
REQ-036 sync_win falls after 30 sync pulses -> sync_abort 1 tick, state RUN, next trigger edge transmitted normally.
REQ-037 clk_locked drops with bits 0 and 3 pending -> no pulses; on relock no stale pulses are sent.
REQ-038 resethist in the same tick as a bit-0 transmission (STATS_EN defined) -> sent_count[0]=0.
